// File: rtl/sha256_job_arbiter.sv
// sha256_job_arbiter
//   Shares one simplified_sha256 hash core among NUM_REQ requesters. Each
//   requester posts a job (message base address + output base address); the
//   arbiter grants round-robin, launches the core, waits for its level-style
//   done and returns a one-cycle ack (with err if the watchdog expired).
//
// Ports
//   clk                in   single clock, rising edge
//   reset              in   synchronous, active-high
//   req                in   [NUM_REQ]    per-requester job request, held until ack
//   req_msg_addr       in   [16*NUM_REQ] message base address, slice i = requester i
//   req_out_addr       in   [16*NUM_REQ] output base address, slice i = requester i
//   ack                out  [NUM_REQ]    one-cycle completion pulse to the granted requester
//   err                out  high with ack when the job timed out
//   grant_id           out  [3]  current or last granted requester
//   busy               out  high in every state except IDLE
//   job_count          out  [16] completed jobs (including errored), wraps
//   core_start         out  start pulse to the hash core
//   core_message_addr  out  [16] registered message address to the core
//   core_output_addr   out  [16] registered output address to the core
//   core_done          in   core done, high whenever the core is idle
module sha256_job_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  req_msg_addr,
  input  logic [16*NUM_REQ-1:0]  req_out_addr,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   err,
  output logic [2:0]             grant_id,
  output logic                   busy,
  output logic [15:0]            job_count,
  output logic                   core_start,
  output logic [15:0]            core_message_addr,
  output logic [15:0]            core_output_addr,
  input  logic                   core_done
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_ACK       = 3'd4;

  // One extra bit so the counter can never wrap back below the limit.
  localparam logic [16:0] TIMEOUT_LIM = 17'(TIMEOUT_CYCLES);

  logic [2:0]  r_state;
  logic [2:0]  r_ptr;
  logic [2:0]  r_grant;
  logic        r_mask_vld;
  logic        r_err_pend;
  logic [16:0] r_cnt;
  logic [15:0] r_job_count;
  logic [15:0] r_msg_addr;
  logic [15:0] r_out_addr;

  logic [NUM_REQ-1:0] w_mask;
  logic [NUM_REQ-1:0] w_eff_req;
  logic [3:0]         w_idx;
  logic               w_found;
  logic [2:0]         w_sel;
  logic [15:0]        w_sel_msg;
  logic [15:0]        w_sel_out;
  logic [16:0]        w_cnt_inc;
  logic               w_timeout;

  // Round-robin pick: scan from r_ptr upward, wrapping modulo NUM_REQ. The
  // last-served requester is masked only in the first IDLE cycle after ACK so
  // a requester holding req high cannot be re-granted back to back.
  always_comb begin
    w_mask    = '0;
    w_idx     = '0;
    w_found   = 1'b0;
    w_sel     = '0;
    w_sel_msg = '0;
    w_sel_out = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_mask[i] = r_mask_vld && (r_grant == 3'(i));
    end
    w_eff_req = req & ~w_mask;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = {1'b0, r_ptr} + 4'(i);
      if (w_idx >= 4'(NUM_REQ)) begin
        w_idx = w_idx - 4'(NUM_REQ);
      end
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!w_found && (w_idx == 4'(j)) && w_eff_req[j]) begin
          w_found = 1'b1;
          w_sel   = 3'(j);
        end
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_sel == 3'(i)) begin
        w_sel_msg = req_msg_addr[16*i +: 16];
        w_sel_out = req_out_addr[16*i +: 16];
      end
    end
  end

  // The counter is cleared on grant and counts every cycle from START on, so
  // it holds N in the Nth cycle after START; ACK lands exactly TIMEOUT_CYCLES
  // cycles after START when the watchdog fires.
  assign w_cnt_inc = r_cnt + 17'd1;
  assign w_timeout = (w_cnt_inc >= TIMEOUT_LIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_grant     <= '0;
      r_mask_vld  <= 1'b0;
      r_err_pend  <= 1'b0;
      r_cnt       <= '0;
      r_job_count <= '0;
      r_msg_addr  <= '0;
      r_out_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_mask_vld <= 1'b0;
          if (w_found) begin
            r_grant    <= w_sel;
            r_msg_addr <= w_sel_msg;
            r_out_addr <= w_sel_out;
            r_cnt      <= '0;
            r_state    <= S_START;
          end
        end
        S_START: begin
          // core_done may still be high from the previous idle period; it is
          // only trusted after the core has been seen busy.
          r_cnt   <= w_cnt_inc;
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          r_cnt <= w_cnt_inc;
          if (!core_done) begin
            r_state <= S_WAIT_DONE;
          end else if (w_timeout) begin
            r_err_pend <= 1'b1;
            r_state    <= S_ACK;
          end
        end
        S_WAIT_DONE: begin
          r_cnt <= w_cnt_inc;
          // Done takes priority over a coinciding watchdog expiry.
          if (core_done) begin
            r_state <= S_ACK;
          end else if (w_timeout) begin
            r_err_pend <= 1'b1;
            r_state    <= S_ACK;
          end
        end
        S_ACK: begin
          r_job_count <= r_job_count + 16'd1;
          r_ptr       <= (r_grant == 3'(NUM_REQ - 1)) ? 3'd0 : r_grant + 3'd1;
          r_mask_vld  <= 1'b1;
          r_err_pend  <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs are pure decodes of registered state.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      ack[i] = (r_state == S_ACK) && (r_grant == 3'(i));
    end
  end

  assign err               = (r_state == S_ACK) && r_err_pend;
  assign grant_id          = r_grant;
  assign busy              = (r_state != S_IDLE);
  assign job_count         = r_job_count;
  assign core_start        = (r_state == S_START);
  assign core_message_addr = r_msg_addr;
  assign core_output_addr  = r_out_addr;

endmodule
